// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline types: register address width, load-tracking slot record
// and the debug encoding of the load-use hazard unit.
package mips_pipe_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned DBG_STATE_W = 2;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
  } slot_t;

  typedef enum logic [DBG_STATE_W-1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } dbg_state_e;

  // True when an in-flight load writes a register the ID instruction reads; $0 never matches.
  function automatic logic slot_match(
    input slot_t                 slot,
    input logic [REG_ADDR_W-1:0] rs_addr,
    input logic [REG_ADDR_W-1:0] rt_addr,
    input logic                  rs_used,
    input logic                  rt_used
  );
    logic rs_hit;
    logic rt_hit;
    rs_hit = rs_used && (slot.addr == rs_addr);
    rt_hit = rt_used && (slot.addr == rt_addr);
    return slot.valid && (slot.addr != '0) && (rs_hit || rt_hit);
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// One load-tracking slot: a {valid, addr} register with hold/load enables and
// async clear, plus the comparator against the ID source registers.
module hazard_slot
  import mips_pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold_i,
  input  logic                  load_i,
  input  logic                  valid_i,
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  input  logic [REG_ADDR_W-1:0] rt_addr_i,
  input  logic                  rs_used_i,
  input  logic                  rt_used_i,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] addr_o,
  output logic                  match_o
);

  slot_t slot_q;
  slot_t slot_d;

  // Hold wins over load so a frozen back end keeps its loads in place.
  always_comb begin
    slot_d = slot_q;
    if (load_i && !hold_i) begin
      slot_d.valid = valid_i;
      slot_d.addr  = addr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign valid_o = slot_q.valid;
  assign addr_o  = slot_q.addr;
  assign match_o = slot_match(slot_q, rs_addr_i, rt_addr_i, rs_used_i, rt_used_i);

endmodule

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detection for the 5-stage MIPS pipeline: tracks lw destinations
// in EX and MEM, stalls/bubbles until WB->ID forwarding covers the operand, and
// freezes the back end while data memory is busy. STALL_COUNT_EN adds stall_cycles.
module load_use_hazard_unit
  import mips_pipe_pkg::*;
`ifdef STALL_COUNT_EN
#(
  parameter int unsigned CNT_W = 32
)
`endif
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  rsAddr_id,
  input  logic [REG_ADDR_W-1:0]  rtAddr_id,
  input  logic                   rs_used_id,
  input  logic                   rt_used_id,
  input  logic                   MemRead_id,
  input  logic [REG_ADDR_W-1:0]  RegWriteAddr_id,
  input  logic                   flush_ex,
  input  logic                   dmem_ready,
  output logic                   stall_front,
  output logic                   bubble_ex,
  output logic                   freeze_back,
  output logic [DBG_STATE_W-1:0] dbg_state
`ifdef STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0]       stall_cycles
`endif
);

  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_addr;
  logic                  ex_match;
  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_addr;
  logic                  mem_match;
  logic                  hazard;
  logic                  mem_wait;
  logic                  capture;
  dbg_state_e            dbg_state_c;

  hazard_slot u_ex_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold_i    (mem_wait),
    .load_i    (1'b1),
    .valid_i   (capture),
    .addr_i    (RegWriteAddr_id),
    .rs_addr_i (rsAddr_id),
    .rt_addr_i (rtAddr_id),
    .rs_used_i (rs_used_id),
    .rt_used_i (rt_used_id),
    .valid_o   (ex_valid),
    .addr_o    (ex_addr),
    .match_o   (ex_match)
  );

  hazard_slot u_mem_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold_i    (mem_wait),
    .load_i    (1'b1),
    .valid_i   (ex_valid),
    .addr_i    (ex_addr),
    .rs_addr_i (rsAddr_id),
    .rt_addr_i (rtAddr_id),
    .rs_used_i (rs_used_id),
    .rt_used_i (rt_used_id),
    .valid_o   (mem_valid),
    .addr_o    (mem_addr),
    .match_o   (mem_match)
  );

  // A tracked load never targets $0, so the address test only restates slot validity.
  always_comb begin
    hazard   = id_valid && (ex_match || mem_match);
    mem_wait = mem_valid && (mem_addr != '0) && !dmem_ready;
    capture  = id_valid && MemRead_id && (RegWriteAddr_id != '0) && !hazard && !flush_ex;
  end

  // Memory wait dominates: slots hold, so a bubble would only duplicate the EX instruction.
  always_comb begin
    stall_front = hazard || mem_wait;
    bubble_ex   = hazard && !mem_wait;
    freeze_back = mem_wait;
  end

  always_comb begin
    dbg_state_c = ST_RUN;
    if (mem_wait) begin
      dbg_state_c = ST_MEM_WAIT;
    end else if (hazard) begin
      dbg_state_c = ST_LOAD_STALL;
    end
  end

  assign dbg_state = dbg_state_c;

`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturating count of cycles with the front end stalled.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_front && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;
`endif

endmodule
